serial_add_arbiter: RTL and testbench

SERIAL_ADD_ARBITER -- requirements
Module: serial_add_arbiter

---
 rtl/serial_add_arbiter.sv | 82 ++++++++
 tb/tb_serial_add_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter: two-requester bit-serial adder (ports clk rst req0/a0/b0 req1/a1/b1 -> ack0 ack1 sum cout busy); define SERIAL_ADD_RR_EN for round-robin arbitration, else req0 has fixed priority
module serial_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, cout_q, cout_d, gnt_q, gnt_d;
  logic win, accept, step, last, h1_s, h1_c, h2_c, fs, fc;
  assign h1_s = a_q[0] ^ b_q[0];
  assign h1_c = a_q[0] & b_q[0];
  assign fs   = h1_s ^ carry_q;
  assign h2_c = h1_s & carry_q;
  assign fc   = h1_c | h2_c;
  assign last   = cnt_q == CW'(WIDTH);
  assign accept = (state_q == IDLE) && (req0 || req1);
  assign step   = (state_q == CALC) && !last;
`ifdef SERIAL_ADD_RR_EN
  logic rr_q, rr_d;
  assign win  = (req0 && req1) ? rr_q : !req0;
  assign rr_d = accept ? ~win : rr_q;
  always_ff @(posedge clk)
    rr_q <= rst ? 1'b0 : rr_d;
`else
  assign win = !req0;
`endif
  always_comb begin
    state_d = (state_q == IDLE) ? (accept ? CALC : IDLE) :
              (state_q == CALC) ? (last ? DONE : CALC) : IDLE;
    a_d     = accept ? (win ? a1 : a0) : step ? a_q >> 1 : a_q;
    b_d     = accept ? (win ? b1 : b0) : step ? b_q >> 1 : b_q;
    sum_d   = step ? (sum_q >> 1) | (WIDTH'(fs) << (WIDTH - 1)) : sum_q;
    carry_d = accept ? 1'b0 : step ? fc : carry_q;
    cout_d  = step ? fc : cout_q;
    cnt_d   = accept ? '0 : step ? cnt_q + CW'(1) : cnt_q;
    gnt_d   = accept ? win : gnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      gnt_q   <= gnt_d;
    end
  end
  assign ack0 = (state_q == DONE) && !gnt_q;
  assign ack1 = (state_q == DONE) && gnt_q;
  assign busy = state_q != IDLE;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_add_arbiter.sv
// tb_serial_add_arbiter: directed checks of serial_add_arbiter at WIDTH=8 and WIDTH=1
module tb_serial_add_arbiter;
  logic clk = 0, rst = 1;
  logic req0 = 0, req1 = 0;
  logic [7:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic ack0, ack1, cout, busy;
  logic [7:0] sum;
  logic w_req0 = 0;
  logic [0:0] w_a0 = 0, w_b0 = 0, w_sum;
  logic w_ack0, w_ack1, w_cout, w_busy;
  int pass_cnt = 0, chk_cnt = 0;
  int n;
  logic id;
  always #5 clk = ~clk;
  serial_add_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req0(req0), .a0(a0), .b0(b0), .req1(req1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .sum(sum), .cout(cout), .busy(busy)
  );
  serial_add_arbiter #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst(rst), .req0(w_req0), .a0(w_a0), .b0(w_b0), .req1(1'b0), .a1(1'b0), .b1(1'b0),
    .ack0(w_ack0), .ack1(w_ack1), .sum(w_sum), .cout(w_cout), .busy(w_busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic wait_any(output int cnt, output logic who);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!(ack0 || ack1) && cnt < 40);
    check("ack_excl", {31'd0, ack0 & ack1}, 0);
    who = ack1;
  endtask
  initial begin
    @(negedge clk);
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_ack", {ack0, ack1}, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_w1", {w_busy, w_ack0, w_ack1, w_sum, w_cout}, 0);
    rst = 0;
    req0 = 1; a0 = 8'h0F; b0 = 8'h01;
    tick();
    check("t1_busy", busy, 1);
    wait_any(n, id);
    check("t1_lat", n, 9);
    check("t1_id", id, 0);
    check("t1_sum", sum, 8'h10);
    check("t1_cout", cout, 0);
    req0 = 0;
    tick();
    check("t1_pulse", {ack0, ack1, busy}, 0);
    repeat (2) tick();
    check("t1_hold", {cout, sum}, 9'h010);
    req1 = 1; a1 = 8'hFF; b1 = 8'h01;
    wait_any(n, id);
    check("t2_lat", n, 10);
    check("t2_id", id, 1);
    check("t2_sum", sum, 8'h00);
    check("t2_cout", cout, 1);
    req1 = 0;
    tick();
    req0 = 1; a0 = 8'd3; b0 = 8'd4; req1 = 1; a1 = 8'd10; b1 = 8'd20;
    wait_any(n, id);
    check("t3a_lat", n, 10);
    check("t3a_id", id, 0);
    check("t3a_sum", sum, 8'h07);
    req0 = 0;
    wait_any(n, id);
    check("t3b_lat", n, 11);
    check("t3b_id", id, 1);
    check("t3b_sum", sum, 8'h1E);
    check("t3b_cout", cout, 0);
    req1 = 0;
    tick();
    req0 = 1; a0 = 8'h33; b0 = 8'h44;
    repeat (4) tick();
    check("t4_calc_busy", busy, 1);
    rst = 1; req0 = 0;
    tick();
    check("t4_abort_ack", {ack0, ack1}, 0);
    check("t4_abort_sum", sum, 0);
    check("t4_abort_cout", cout, 0);
    check("t4_abort_busy", busy, 0);
    rst = 0; req0 = 1; a0 = 8'h55; b0 = 8'hAA;
    wait_any(n, id);
    check("t4_lat", n, 10);
    check("t4_id", id, 0);
    check("t4_sum", sum, 8'hFF);
    check("t4_cout", cout, 0);
    req0 = 0;
    tick();
    req0 = 1; a0 = 8'h12; b0 = 8'h34;
    tick();
    req0 = 0; a0 = 8'hFF; b0 = 8'hFF;
    wait_any(n, id);
    check("t5_lat", n, 9);
    check("t5_id", id, 0);
    check("t5_sum", sum, 8'h46);
    check("t5_cout", cout, 0);
    tick();
    req0 = 1; a0 = 8'd1; b0 = 8'd2; req1 = 1; a1 = 8'd5; b1 = 8'd6;
    wait_any(n, id);
    check("t6a_lat", n, 10);
`ifdef SERIAL_ADD_RR_EN
    check("t6a_id", id, 1);
    check("t6a_sum", sum, 8'h0B);
    req1 = 0;
`else
    check("t6a_id", id, 0);
    check("t6a_sum", sum, 8'h03);
    req0 = 0;
`endif
    wait_any(n, id);
    check("t6b_lat", n, 11);
`ifdef SERIAL_ADD_RR_EN
    check("t6b_id", id, 0);
    check("t6b_sum", sum, 8'h03);
`else
    check("t6b_id", id, 1);
    check("t6b_sum", sum, 8'h0B);
`endif
    req0 = 0; req1 = 0;
    tick();
    w_req0 = 1; w_a0 = 1; w_b0 = 1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!w_ack0 && n < 20);
    check("w1_lat", n, 3);
    check("w1_ack1", w_ack1, 0);
    check("w1_sum", w_sum, 0);
    check("w1_cout", w_cout, 1);
    w_req0 = 0;
    tick();
    check("w1_pulse", {w_ack0, w_busy}, 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
